// File: rtl/load_store_unit.sv
// load_store_unit: initiator-side access controller between the datapath and a
// single-cycle, word-addressed data memory. It turns byte, halfword and word
// loads and stores into word transactions. Sub-word stores use
// read-modify-write, and sub-word loads are sign- or zero-extended. Misaligned
// requests are rejected without any memory access.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to also reject requests whose
// word address (addr[31:2]) is at or beyond DEPTH. Without it, the word
// address wraps modulo DEPTH.
//
// Ports:
//   clock_i, reset_i    clock, asynchronous active-high reset
//   req_i, we_i         request strobe (sampled in IDLE), 1 = store
//   size_i              00 byte, 01 halfword, 1x word
//   load_signed_i       sign-extend sub-word loads when 1
//   addr_i, wdata_i     byte address, store data
//   busy_o, done_o      not-idle flag, one-cycle completion pulse
//   err_o               access rejected (valid with done_o)
//   rdata_o             last successful load result
//   mem_addr_o          word address to memory
//   mem_wdata_o         word to write
//   mem_write_o         memory write enable
//   mem_rdata_i         combinational read data for mem_addr_o
module load_store_unit #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              load_signed_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, done_q, mem_write_q;
  logic                misaligned_c;
  logic                reject_c;

  // Halfword needs addr[0]=0; word (size 1x) needs addr[1:0]=0.
  assign misaligned_c = ((size_i == 2'b01) && addr_i[0]) ||
                        (size_i[1] && (addr_i[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
  assign reject_c = misaligned_c || (addr_i[31:2] >= 30'(DEPTH));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];
  assign reject_c = misaligned_c;
`endif

  // Replace the addressed byte or halfword lane of the word read back.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_w;
    if (sz == 2'b00) w[{lane, 3'b000} +: 8] = wd[7:0];
    else             w[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return w;
  endfunction

  // Select the loaded lane and extend it to 32 bits.
  function automatic logic [31:0] extend_lane(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic        sgn,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    if (sz[1])              return w;
    else if (sz == 2'b01)   return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
    else                    return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
  endfunction

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          sgn_d   = load_signed_i;
          lane_d  = addr_i[1:0];
          wdata_d = wdata_i;
          addr_d  = addr_i[ADDR_W+1:2];
          err_d   = reject_c;
          if (reject_c) begin
            state_d = S_DONE;
          end else if (we_i && size_i[1]) begin
            mem_wdata_d = wdata_i;
            state_d     = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          mem_wdata_d = merge_lane(mem_rdata_i, wdata_q, size_q, lane_q);
          state_d     = S_WRITE;
        end else begin
          rdata_d = extend_lane(mem_rdata_i, size_q, sgn_q, lane_q);
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; status outputs decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      mem_write_q <= (state_d == S_WRITE);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_write_o = mem_write_q;

endmodule
